// File: rtl/ball_if.sv
// ball_if: controls, map ROM query and game-state bundle between the motion controller and its peers
interface ball_if;
    logic        frame_tick;
    logic        start;
    logic        left;
    logic        right;
    logic        jump;
    logic        tile_solid;
    logic [2:0]  q_index_x;
    logic [10:0] q_index_y;
    logic [9:0]  x_ball;
    logic [25:0] y_ball;
    logic [2:0]  ball_state;
    logic        fail;
    logic        win;
    modport master (
        input  frame_tick, start, left, right, jump, tile_solid,
        output q_index_x, q_index_y, x_ball, y_ball, ball_state, fail, win
    );
    modport slave (
        output frame_tick, start, left, right, jump, tile_solid,
        input  q_index_x, q_index_y, x_ball, y_ball, ball_state, fail, win
    );
endinterface

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame ball steering, scrolling, jump arc and tile-support check
module ball_motion_ctrl #(
    parameter int X_START  = 200,
    parameter int X_MAX    = 399,
    parameter int X_STEP   = 4,
    parameter int Y_SPEED  = 4,
    parameter int ROW_LEN  = 80,
    parameter int LANE_W   = 50,
    parameter int WIN_ROWS = 201,
    parameter int HOLD     = 4
) (
    input logic   clk,
    input logic   rst,
    ball_if.master bus
);
    typedef enum logic [2:0] {IDLE, RUN, AIR, CHECK, FALL, DEAD, WON} state_t;
    state_t      st_q;
    logic [9:0]  x_q, x_d, lane_d;
    logic [25:0] y_q, y_d;
    logic [2:0]  bs_q, bs_step, cnt_q, qx_q, qx_d;
    logic [10:0] qy_q, qy_d;
    logic        fail_q, win_q, up_q, win_hit;
    always_comb begin
        x_d = (bus.left && !bus.right) ? (x_q >= 10'(X_STEP) ? x_q - 10'(X_STEP) : '0) :
              (bus.right && !bus.left) ? (x_q + 10'(X_STEP) > 10'(X_MAX) ? 10'(X_MAX) : x_q + 10'(X_STEP)) :
              x_q;
        y_d = y_q + 26'(Y_SPEED);
        lane_d = x_d / 10'(LANE_W);
        qx_d = lane_d > 10'd7 ? 3'd7 : lane_d[2:0];
        qy_d = 11'(y_d / 26'(ROW_LEN));
        win_hit = y_d > 26'(WIN_ROWS * ROW_LEN);
        bs_step = up_q ? bs_q + 3'd1 : bs_q - 3'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            x_q    <= 10'(X_START);
            y_q    <= '0;
            bs_q   <= 3'd1;
            fail_q <= 1'b0;
            win_q  <= 1'b0;
            up_q   <= 1'b0;
            cnt_q  <= '0;
            qx_q   <= 3'(X_START / LANE_W);
            qy_q   <= '0;
        end else begin
            case (st_q)
                IDLE: if (bus.frame_tick && bus.start) st_q <= RUN;
                RUN, AIR: if (bus.frame_tick) begin
                    x_q   <= x_d;
                    y_q   <= y_d;
                    qx_q  <= qx_d;
                    qy_q  <= qy_d;
                    cnt_q <= '0;
                    if (win_hit) begin
                        st_q  <= WON;
                        win_q <= 1'b1;
                        bs_q  <= 3'd1;
                    end else if (st_q == RUN) begin
                        if (bus.jump) begin
                            st_q <= AIR;
                            bs_q <= 3'd2;
                            up_q <= 1'b1;
                        end else st_q <= CHECK;
                    end else if (cnt_q == 3'(HOLD - 1)) begin
                        // up_q drops once the apex (5) is reached
                        bs_q <= bs_step;
                        up_q <= up_q && bs_step != 3'd5;
                        if (bs_step == 3'd1) st_q <= CHECK;
                    end else cnt_q <= cnt_q + 3'd1;
                end
                CHECK: if (cnt_q == 3'd2) begin
                    cnt_q <= '0;
                    if (bus.tile_solid) st_q <= RUN;
                    else begin
                        st_q <= FALL;
                        bs_q <= 3'd0;
                    end
                end else cnt_q <= cnt_q + 3'd1;
                FALL: if (bus.frame_tick) begin
                    if (cnt_q == 3'(HOLD - 1)) begin
                        st_q   <= DEAD;
                        fail_q <= 1'b1;
                    end else cnt_q <= cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end
    assign bus.x_ball     = x_q;
    assign bus.y_ball     = y_q;
    assign bus.ball_state = bs_q;
    assign bus.fail       = fail_q;
    assign bus.win        = win_q;
    assign bus.q_index_x  = qx_q;
    assign bus.q_index_y  = qy_q;
endmodule
